// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   - FSM state encoding (legacy 2-bit constants)
//   - default register-address width
//   - pipe_ctrl_t: one bundle of PC / latch controls, plus the canned
//     control words the controller drives in each situation
//   - BUBBLE_CTRL: control-field value a flushed pipeline latch loads
package pipeline_pkg;

  localparam int PKG_REG_W = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_en;
    logic id_ex_en;
    logic ex_m_en;
    logic m_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_m_flush;
    logic m_wb_flush;
  } pipe_ctrl_t;

  // Normal free-running pipeline.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, pc_src: 1'b0,
    if_id_en: 1'b1, id_ex_en: 1'b1, ex_m_en: 1'b1, m_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_m_flush: 1'b0, m_wb_flush: 1'b0};

  // Driven while in (or just out of) reset: nothing loads, every latch clears.
  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, pc_src: 1'b0,
    if_id_en: 1'b0, id_ex_en: 1'b0, ex_m_en: 1'b0, m_wb_en: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_m_flush: 1'b1, m_wb_flush: 1'b1};

  // Memory stall: freeze front of pipe, push a bubble into WB.
  localparam pipe_ctrl_t CTRL_MEMWAIT = '{
    pc_write: 1'b0, pc_src: 1'b0,
    if_id_en: 1'b0, id_ex_en: 1'b0, ex_m_en: 1'b0, m_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_m_flush: 1'b0, m_wb_flush: 1'b1};

  // Dead pipeline: everything frozen, nothing cleared.
  localparam pipe_ctrl_t CTRL_HALT = '0;

  // A flushed latch holds all-zero control fields (a no-op bubble).
  localparam logic [15:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare for the decode stage.
//   in : if_id_rs/rt, if_id_uses_rt  - decode instruction sources
//        id_ex_mem_read, id_ex_rt    - load in EX and its destination
//   out: load_use                    - decode must wait one cycle
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_W = PKG_REG_W
) (
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  output logic             load_use
);

  // r0 is hardwired zero, so a load "to r0" never produces a dependency.
  assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) ||
                     (if_id_uses_rt && (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
//   in : clk, rst_n (async, active low)
//        decode sources, EX load info, EX/M branch/mem flags, dmem_ready
//   out: pc_write, pc_src, per-latch en/flush, halted, stall_count
// Controls are Mealy outputs of the FSM (RUN / MEM_WAIT / HALT).
// Priority: memory wait > taken branch > load-use.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W       = PKG_REG_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic             m_branch,
  input  logic             m_zero,
  input  logic             m_mem_read,
  input  logic             m_mem_write,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_m_en,
  output logic             m_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_m_flush,
  output logic             m_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              halted_q, halted_d;
  // Low from reset until the first rising edge after release, so the reset
  // control word persists until that edge and the FSM starts on it.
  logic              live_q, live_d;

  logic       load_use;
  logic       mem_acc;
  logic       taken;
  pipe_ctrl_t ctrl;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_uses_rt  (if_id_uses_rt),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rt       (id_ex_rt),
    .load_use       (load_use)
  );

  assign mem_acc = m_mem_read | m_mem_write;
  assign taken   = m_branch & m_zero;

  always_comb begin
    ctrl          = CTRL_RUN;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    halted_d      = halted_q;
    stall_count_d = stall_count_q;
    live_d        = 1'b1;

    if (!live_q) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_acc && !dmem_ready) begin
            ctrl       = CTRL_MEMWAIT;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = '0;
          end else if (taken) begin
            // Squash the three younger instructions, including any
            // load-use victim in decode, so no stall is needed.
            ctrl.pc_src      = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            ctrl.ex_m_flush  = 1'b1;
          end else if (load_use) begin
            // One bubble: next cycle EX holds the bubble, so no repeat.
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            ctrl       = CTRL_MEMWAIT;
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_q == WCNT_LAST) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
          end else begin
            // Access completes: plain RUN controls this cycle.
            state_d = ST_RUN;
          end
        end
        ST_HALT: ctrl = CTRL_HALT;
        default: begin
          ctrl    = CTRL_HALT;
          state_d = ST_RUN;
        end
      endcase

      if ((state_q != ST_HALT) && !ctrl.pc_write && (stall_count_q != '1))
        stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      halted_q      <= 1'b0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      halted_q      <= halted_d;
      live_q        <= live_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_src      = ctrl.pc_src;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_m_en     = ctrl.ex_m_en;
  assign m_wb_en     = ctrl.m_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_m_flush  = ctrl.ex_m_flush;
  assign m_wb_flush  = ctrl.m_wb_flush;
  assign halted      = halted_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the five-stage pipeline. It produces the enable and flush controls for the PC and the IF/ID, ID/EX, EX/M and M/WB latches. It resolves three conditions: load-use hazards in decode, taken branches resolved from the EX/M latch outputs, and multi-cycle data-memory accesses. It also detects a memory timeout and keeps a saturating stall counter.

## Interface
- `REG_W`, 5, register-address width.
- `MEM_TIMEOUT`, 64, maximum MEM_WAIT cycles before halt (≥2).
- `CNT_W`, 16, stall counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_id_rs`, `if_id_rt` in REG_W: source registers of the instruction in decode.
- `if_id_uses_rt` in 1: the decode instruction reads rt.
- `id_ex_mem_read` in 1, `id_ex_rt` in REG_W: the EX-stage instruction is a load, and its destination.
- `m_branch`, `m_zero`, `m_mem_read`, `m_mem_write` in 1: EX/M latch outputs.
- `dmem_ready` in 1: the data memory completes this cycle.
- `pc_write`, `pc_src` out 1: PC load enable, and the branch-target select.
- `if_id_en`, `id_ex_en`, `ex_m_en`, `m_wb_en` out 1: latch load enables.
- `if_id_flush`, `id_ex_flush`, `ex_m_flush`, `m_wb_flush` out 1: synchronous clear of the latch to a bubble (all controls 0). Flush overrides enable.
- `halted` out 1: sticky memory-timeout flag.
- `stall_count` out CNT_W: saturating stall-cycle counter.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. All control outputs are combinational (Mealy) from the state and inputs. The state, the wait counter, `stall_count` and `halted` are registered.
- Default in RUN: `pc_write`=1, every enable =1, every flush =0, `pc_src`=0.
- Let `mem_acc` = `m_mem_read` | `m_mem_write`.
- Condition priority, highest first: memory wait, then taken branch, then load-use.
- **Memory wait.** Triggered in RUN by `mem_acc` & !`dmem_ready`, or in MEM_WAIT by !`dmem_ready`.
  - `pc_write`, `if_id_en`, `id_ex_en`, `ex_m_en` =0; `m_wb_flush`=1.
  - RUN moves to MEM_WAIT.
  - In MEM_WAIT, `dmem_ready`=1 applies the RUN defaults for that cycle and returns to RUN.
- **Taken branch.** `m_branch` & `m_zero` with no memory wait.
  - `pc_src`=1, `pc_write`=1.
  - `if_id_flush`, `id_ex_flush`, `ex_m_flush` =1.
  - Any load-use hit in the same cycle is ignored; its instruction is flushed.
- **Load-use.** `id_ex_mem_read` & `id_ex_rt`≠0 & (`id_ex_rt`==`if_id_rs` | (`if_id_uses_rt` & `id_ex_rt`==`if_id_rt`)).
  - `pc_write`=0, `if_id_en`=0, `id_ex_flush`=1.
  - Produces exactly one bubble; the next cycle sees a bubble in EX, so there is no repeat.
- **Wait counter.** Cleared on entry to MEM_WAIT and incremented on each MEM_WAIT cycle with `dmem_ready`=0.
  - If the counter equals MEM_TIMEOUT-1 and `dmem_ready`=0, the next state is HALT.
  - `dmem_ready`=1 always wins over the timeout.
- **HALT.**
  - `pc_write`=0; all enables =0; all flushes =0.
  - `halted`=1; the block leaves HALT only through reset.
- **Stall counter.** `stall_count` increments each cycle in RUN or MEM_WAIT in which `pc_write`=0. It saturates at 2^CNT_W-1 and does not count in HALT.

## Timing
- While `rst_n`=0, and after the asynchronous reset:
  - state = RUN, wait counter = 0, `stall_count`=0, `halted`=0.
  - Outputs while reset is asserted: `pc_write`=0, enables =0, flushes =1, `pc_src`=0.
- On deassertion, the RUN defaults apply from the first rising edge.
- Latency from a condition to its control output is 0 cycles (same cycle).
- A zero-wait memory access (`dmem_ready`=1 in the first cycle) adds no stall.
- An N-cycle memory access stalls for N-1 cycles.
- Reset asserted in MEM_WAIT or HALT returns the block to RUN immediately; the counter and flag clear.
- Register 0 never causes a load-use stall.

## Structure
- Shared package `pipeline_pkg`: the state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2), `REG_W`, and a bubble-control localparam reused by the latches.
- Sub-module `hazard_detect`: the pure-combinational load-use compare. It takes `if_id_*` and `id_ex_*` and produces `load_use`.
- The FSM, the counters and the output muxing stay in `pipeline_ctrl` (roughly 150–250 lines).
- The latches gain `en` and `flush` inputs in the same change.

## Test plan
- **Load-use:** `id_ex_mem_read`=1, `id_ex_rt`=5, `if_id_rs`=5.
  - Required: `pc_write`=0, `if_id_en`=0 and `id_ex_flush`=1 for exactly 1 cycle.
  - Required: `stall_count` 0→1.
- **Taken branch:** `m_branch`=1, `m_zero`=1 together with a load-use hit.
  - Required: `pc_src`=1 and `pc_write`=1.
  - Required: `if_id_flush`, `id_ex_flush` and `ex_m_flush` =1; no stall; `stall_count` unchanged.
- **Slow memory:** `m_mem_read`=1 with `dmem_ready` low for 3 cycles, high on the 4th.
  - Required: freeze and `m_wb_flush`=1 for 3 cycles, RUN defaults on cycle 4.
  - Required: `stall_count`=3, state back to RUN.
- **Timeout:** MEM_TIMEOUT=4, `dmem_ready` held low.
  - Required: state HALT after 4 wait cycles, `halted`=1, all enables 0.
  - Required: only `rst_n`=0 clears the halt.
- **Ready wins:** `dmem_ready`=1 exactly in the timeout cycle.
  - Required: returns to RUN, `halted` stays 0.
- **Reset mid-wait:** `rst_n` pulsed low in MEM_WAIT.
  - Required: outputs go to the reset values asynchronously.
  - Required: RUN with `stall_count`=0 after release.
